i2c_master_read_byte: RTL and testbench

Master-side I2C byte reader, the receive counterpart of the master byte writer.
- Generates SCL, releases SDA, and shifts in 8 data bits MSB-first (READ_DATA), or samples the slave's single ACK/NACK bit (READ_ACK).
- Sits beside the byte writer under the I2C master controller FSM.
- Shares the writer's go/command/finish handshake and 3-bit command encoding.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_master_read_bit.sv | 63 ++++++
 rtl/i2c_master_read_byte.sv | 121 ++++++++++++
 tb/tb_i2c_master_read_byte.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: command codes, byte-FSM states and SCL quarter phases.
// The read codes deliberately reuse the byte writer's DATA/ACK encodings.
package i2c_pkg;

    localparam logic [2:0] CMD_READ_DATA = 3'b011;
    localparam logic [2:0] CMD_READ_ACK  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_DATA = 2'd1,
        ST_RD_ACK  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    function automatic logic is_read_cmd(input logic [2:0] cmd);
        return (cmd == CMD_READ_DATA) || (cmd == CMD_READ_ACK);
    endfunction

endpackage

// File: rtl/i2c_master_read_bit.sv
// One receive bit slot: four SCL quarters of CLK_DIV clocks each, with clock-stretch hold in Q1.
// Counters sit at Q0/phase 0 whenever the slot is not enabled.
module i2c_master_read_bit
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sample_valid,
    output logic sampled_bit,
    output logic bit_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

    quarter_t quarter_q, quarter_d;
    logic [PW-1:0] phase_q, phase_d;
    logic ph_last;
    logic stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            quarter_q <= Q0;
            phase_q   <= '0;
        end else begin
            quarter_q <= quarter_d;
            phase_q   <= phase_d;
        end
    end

    // A slave holding SCL low during the released high phase freezes the phase count.
    always_comb begin
        ph_last   = (phase_q == PH_LAST);
        stall     = enable && (quarter_q == Q1) && !scl_in;
        quarter_d = quarter_q;
        phase_d   = phase_q;
        if (!enable) begin
            quarter_d = Q0;
            phase_d   = '0;
        end else if (!stall) begin
            if (ph_last) begin
                phase_d   = '0;
                quarter_d = quarter_t'(quarter_q + 2'd1);
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_comb begin
        scl          = enable ? ((quarter_q == Q1) || (quarter_q == Q2)) : 1'b1;
        sample_valid = enable && (quarter_q == Q1) && ph_last && !stall;
        sampled_bit  = sda_in;
        bit_done     = enable && (quarter_q == Q3) && ph_last;
    end

endmodule

// File: rtl/i2c_master_read_byte.sv
// Master-side I2C byte reader: clocks in 8 data bits MSB-first or the slave's ACK bit.
//   state   | meaning
//   IDLE    | waiting for go with a valid read command
//   RD_DATA | clocking 8 data bits into the shift register
//   RD_ACK  | clocking the single ACK/NACK bit
//   DONE    | one-cycle finish pulse, result registers updated
module i2c_master_read_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] command,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda,
    output logic [7:0] data_out,
    output logic       ack,
    output logic       busy,
    output logic       finish
);

    state_t     state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       ack_bit_q, ack_bit_d;
    logic [7:0] data_out_q, data_out_d;
    logic       ack_q, ack_d;

    logic bit_enable;
    logic bit_scl;
    logic sample_valid;
    logic sampled_bit;
    logic bit_done;

    assign bit_enable = (state_q == ST_RD_DATA) || (state_q == ST_RD_ACK);

    i2c_master_read_bit #(
        .CLK_DIV (CLK_DIV)
    ) u_bit (
        .clock        (clock),
        .reset        (reset),
        .enable       (bit_enable),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl          (bit_scl),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .bit_done     (bit_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 3'b000;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ack_bit_q  <= 1'b0;
            data_out_q <= 8'h00;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_bit_q  <= ack_bit_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ack_bit_d  = ack_bit_q;
        data_out_d = data_out_q;
        ack_d      = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (go && is_read_cmd(command)) begin
                    cmd_d   = command;
                    state_d = (command == CMD_READ_ACK) ? ST_RD_ACK : ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (sample_valid) shift_d = {shift_q[6:0], sampled_bit};
                // Bit counter wraps 7 -> 0 naturally on the final bit.
                if (bit_done) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_DONE;
                end
            end
            ST_RD_ACK: begin
                if (sample_valid) ack_bit_d = sampled_bit;
                if (bit_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (cmd_q == CMD_READ_ACK) ack_d = ~ack_bit_q;
                else data_out_d = shift_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        finish   = (state_q == ST_DONE);
        scl      = bit_scl;
        sda      = 1'b1;
        data_out = data_out_q;
        ack      = ack_q;
    end

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Directed bench for the I2C byte reader at CLK_DIV = 2 (one bit = 8 clocks).
// A small slave model presents each byte MSB-first, advancing on SCL falling edges.
module tb_i2c_master_read_byte;

    localparam int CLK_DIV = 2;
    localparam logic [2:0] C_DATA = 3'b011;
    localparam logic [2:0] C_ACK  = 3'b111;

    logic       clock;
    logic       reset;
    logic       go;
    logic [2:0] command;
    logic       scl_in;
    logic       sda_in;
    logic       scl;
    logic       sda;
    logic [7:0] data_out;
    logic       ack;
    logic       busy;
    logic       finish;

    logic       stretch;
    logic [7:0] slave_byte;
    int         fall_cnt  = 0;
    int         fall_base = 0;
    int         k;
    logic [2:0] sda_idx;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_master_read_byte #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .go       (go),
        .command  (command),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl      (scl),
        .sda      (sda),
        .data_out (data_out),
        .ack      (ack),
        .busy     (busy),
        .finish   (finish)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wired-AND SCL: the bench can hold the line low to stretch.
    assign scl_in = scl & ~stretch;

    always @(negedge scl) fall_cnt <= fall_cnt + 1;

    // First fall (Q0 of bit 0) presents bit 7; each Q3 fall moves to the next bit.
    always_comb begin
        k = fall_cnt - fall_base;
        if (k <= 1)      sda_idx = 3'd7;
        else if (k >= 8) sda_idx = 3'd0;
        else             sda_idx = 3'(8 - k);
    end
    assign sda_in = slave_byte[sda_idx];

    task automatic run_read(input logic [2:0] cmd, input logic [7:0] byte_val,
                            input int str_start, input int str_len,
                            output int first_fin, output int fin_cnt,
                            output int pulses, output int bad_w, output int sda_bad);
        int   cnt;
        int   run;
        logic prev_scl;
        @(negedge clock);
        fall_base  = fall_cnt;
        slave_byte = byte_val;
        go         = 1'b1;
        command    = cmd;
        cnt = 0; run = 0; prev_scl = 1'b0;
        first_fin = 0; fin_cnt = 0; pulses = 0; bad_w = 0; sda_bad = 0;
        while (cnt < 300 && !(first_fin != 0 && cnt >= first_fin + 2)) begin
            @(posedge clock);
            cnt++;
            @(negedge clock);
            if (cnt == 1) go = 1'b0;
            if (str_len > 0 && cnt == str_start) stretch = 1'b1;
            if (str_len > 0 && cnt == str_start + str_len) stretch = 1'b0;
            if (finish) begin
                fin_cnt++;
                if (first_fin == 0) first_fin = cnt;
            end
            if (sda !== 1'b1) sda_bad++;
            if (scl) run++;
            else begin
                if (prev_scl) begin
                    pulses++;
                    if (run != 4) bad_w++;
                end
                run = 0;
            end
            prev_scl = scl;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; command = 3'b000; stretch = 1'b0; slave_byte = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL reset_scl got %b want 1", scl); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL reset_sda got %b want 1", sda); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish got %b want 0", finish); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_out); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
        reset = 1'b0;
    endtask

    task automatic test_read_data();
        int ff, fc, pu, bw, sb;
        run_read(C_DATA, 8'hA5, 0, 0, ff, fc, pu, bw, sb);
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL rd_data got %h want a5", data_out); end
        n_cmp++; if (ff != 65) begin n_bad++; $display("FAIL rd_latency got %0d want 65", ff); end
        n_cmp++; if (fc != 1) begin n_bad++; $display("FAIL rd_finish_len got %0d want 1", fc); end
        n_cmp++; if (pu != 8) begin n_bad++; $display("FAIL rd_scl_pulses got %0d want 8", pu); end
        n_cmp++; if (bw != 0) begin n_bad++; $display("FAIL rd_scl_width bad=%0d want 0", bw); end
        n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL rd_sda_low count=%0d want 0", sb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_after got %b want 0", busy); end
    endtask

    task automatic test_read_ack();
        int ff, fc, pu, bw, sb;
        run_read(C_ACK, 8'h00, 0, 0, ff, fc, pu, bw, sb);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL ack0 got %b want 1", ack); end
        n_cmp++; if (ff != 9) begin n_bad++; $display("FAIL ack_latency got %0d want 9", ff); end
        n_cmp++; if (pu != 1) begin n_bad++; $display("FAIL ack_pulses got %0d want 1", pu); end
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL ack_data_hold got %h want a5", data_out); end
        run_read(C_ACK, 8'h80, 0, 0, ff, fc, pu, bw, sb);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL ack1 got %b want 0", ack); end
        n_cmp++; if (ff != 9) begin n_bad++; $display("FAIL nack_latency got %0d want 9", ff); end
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL nack_data_hold got %h want a5", data_out); end
    endtask

    task automatic test_stretch();
        int ff, fc, pu, bw, sb;
        // Bit 3 Q1 begins in the cycle after edge 1 + 3*8 + 2 = 27.
        run_read(C_DATA, 8'h3C, 27, 10, ff, fc, pu, bw, sb);
        n_cmp++; if (data_out !== 8'h3C) begin n_bad++; $display("FAIL str_data got %h want 3c", data_out); end
        n_cmp++; if (ff != 75) begin n_bad++; $display("FAIL str_latency got %0d want 75", ff); end
        n_cmp++; if (fc != 1) begin n_bad++; $display("FAIL str_finish_len got %0d want 1", fc); end
    endtask

    task automatic test_reset_mid();
        int cnt, fins;
        int ff, fc, pu, bw, sb;
        @(negedge clock);
        fall_base = fall_cnt; slave_byte = 8'hFF; go = 1'b1; command = C_DATA;
        cnt = 0;
        while (cnt < 36) begin
            @(posedge clock); cnt++;
            @(negedge clock);
            if (cnt == 1) go = 1'b0;
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL mid_scl got %b want 1", scl); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL mid_sda got %b want 1", sda); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL mid_data got %h want 00", data_out); end
        reset = 1'b0;
        fins = 0;
        repeat (80) begin
            @(posedge clock);
            @(negedge clock);
            if (finish) fins++;
        end
        n_cmp++; if (fins != 0) begin n_bad++; $display("FAIL mid_no_finish got %0d want 0", fins); end
        run_read(C_DATA, 8'h5A, 0, 0, ff, fc, pu, bw, sb);
        n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL mid_reread got %h want 5a", data_out); end
        n_cmp++; if (ff != 65) begin n_bad++; $display("FAIL mid_reread_lat got %0d want 65", ff); end
    endtask

    task automatic test_back_to_back();
        int cnt, f1, f2, fins;
        logic busy66, busy67;
        logic [7:0] d66;
        @(negedge clock);
        fall_base = fall_cnt; slave_byte = 8'hC3; go = 1'b1; command = C_DATA;
        cnt = 0; f1 = 0; f2 = 0; fins = 0; busy66 = 1'b1; busy67 = 1'b0; d66 = 8'h00;
        while (cnt < 85) begin
            @(posedge clock); cnt++;
            @(negedge clock);
            if (finish) begin
                fins++;
                if (f1 == 0) begin
                    f1 = cnt;
                    command = C_ACK; fall_base = fall_cnt; slave_byte = 8'h00;
                end else if (f2 == 0) f2 = cnt;
            end
            if (cnt == 66) begin busy66 = busy; d66 = data_out; end
            if (cnt == 67) begin busy67 = busy; go = 1'b0; end
        end
        n_cmp++; if (f1 != 65) begin n_bad++; $display("FAIL b2b_first got %0d want 65", f1); end
        n_cmp++; if (busy66 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap got %b want 0", busy66); end
        n_cmp++; if (busy67 !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got %b want 1", busy67); end
        n_cmp++; if (d66 !== 8'hC3) begin n_bad++; $display("FAIL b2b_data got %h want c3", d66); end
        n_cmp++; if (f2 != 75) begin n_bad++; $display("FAIL b2b_second got %0d want 75", f2); end
        n_cmp++; if (fins != 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", fins); end
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack got %b want 1", ack); end
    endtask

    task automatic test_bad_cmd();
        int busy_n, scl_low, fins;
        @(negedge clock);
        go = 1'b1; command = 3'b001;
        busy_n = 0; scl_low = 0; fins = 0;
        repeat (100) begin
            @(posedge clock);
            @(negedge clock);
            if (busy) busy_n++;
            if (!scl) scl_low++;
            if (finish) fins++;
        end
        go = 1'b0;
        n_cmp++; if (busy_n != 0) begin n_bad++; $display("FAIL bad_busy got %0d want 0", busy_n); end
        n_cmp++; if (scl_low != 0) begin n_bad++; $display("FAIL bad_scl_low got %0d want 0", scl_low); end
        n_cmp++; if (fins != 0) begin n_bad++; $display("FAIL bad_finish got %0d want 0", fins); end
    endtask

    initial begin
        test_reset();
        test_read_data();
        test_read_ack();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        test_bad_cmd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
